tile_framebuffer: RTL
=====================

// Module: tile_framebuffer
// PURPOSE
//  Double-buffered 40x30 monochrome tile store feeding the VGA scan-out stage.
//  Game logic writes tiles into a back buffer via a valid/ready command port.
//  On request, the back buffer is copied to the front buffer at the next vertical sync.
//  The front buffer drives the 1201-bit data bus (bit index = y*40 + x) consumed by the VGA block.
// PARAMETERS
//  COLS   40    tiles per row (640 px / 16)
//  ROWS   30    tile rows (480 px / 16)
//  TILES  1200  COLS*ROWS; width of each buffer
// PORTS
//  clk           in   1     50 MHz system clock
//  reset         in   1     asynchronous, active-high reset
//  cmd_valid     in   1     command present
//  cmd_ready     out  1     command accepted when cmd_valid & cmd_ready at posedge clk
//  cmd_op        in   2     00 SET, 01 CLEAR, 10 TOGGLE, 11 FILL (whole back buffer := cmd_value)
//  cmd_x         in   6     tile column 0..39
//  cmd_y         in   5     tile row 0..29
//  cmd_value     in   1     fill value for FILL; ignored otherwise
//  swap_req      in   1     1-cycle pulse: request back->front copy at next vsync
//  v_sync        in   1     active-low vertical sync from the VGA stage
//  swap_pending  out  1     swap requested, not yet performed
//  busy          out  1     FILL sweep in progress
//  data          out  1201  {1'b0, front[1199:0]} to VGA data input
// BEHAVIOUR
//  Reset (async, immediate): back=0, front=0, data=0, cmd_ready=1, busy=0, swap_pending=0,
//   FSM=IDLE, v_sync synchronizer flops=1.
//  data[1200] is tied 0; data[1199:0] = front register, no combinational path from cmd_*.
//  Addressing: idx = cmd_y*40 + cmd_x (11-bit). Commands with x>39 or y>29 are accepted
//   (handshake completes) and discarded; no buffer bit changes.
//  FSM IDLE: cmd_ready=1. SET/CLEAR/TOGGLE update back[idx] on the accepting edge
//   (visible in back one cycle later). FILL: latch cmd_value, row counter:=0, go FILL.
//  FSM FILL: cmd_ready=0, busy=1. Each cycle writes back[row*40 +: 40] := {40{fill_value}},
//   row++. After row 29 is written -> IDLE. Total 30 cycles; cmd_ready returns high on cycle 31.
//  Vsync detect: v_sync -> 2-flop synchronizer (s1,s2) -> s3; vs_fall = s3 & ~s2.
//  Swap: swap_req sets swap_pending (re-pulsing while pending has no extra effect).
//   If vs_fall && swap_pending && FSM==IDLE: front := back (copy; back keeps its content),
//   swap_pending := 0. Front updates on the 3rd rising clk edge after v_sync falls.
//  Simultaneous events:
//   - swap_req and vs_fall on the same cycle with no pending swap: no copy this frame;
//     swap_pending set, copy at the following vsync.
//   - vs_fall while FSM==FILL: copy deferred; swap_pending stays 1; copy happens at the
//     next vs_fall seen in IDLE (never mid-fill; no torn frames).
//   - Command accepted on the same edge as the copy: front receives back as it was
//     BEFORE that command; the command lands in back only.
//  Reset mid-FILL or with swap pending: all state cleared; pending swap lost.
// TESTING
//  1 Reset: assert reset mid-frame -> data==0, cmd_ready==1, busy==0, swap_pending==0.
//  2 SET (x=3,y=2), swap_req, drop v_sync -> after 3 clk data[83]==1, all other bits 0;
//    before v_sync edge, data unchanged.
//  3 TOGGLE (39,29) twice, then (0,0) once, swap -> data[1199]==0, data[0]==1; CLEAR (0,0),
//    swap -> data[0]==0.
//  4 FILL value=1 -> busy high exactly 30 cycles, cmd_ready low during them; swap -> data[1199:0]
//    all ones, data[1200]==0.
//  5 swap_req then v_sync falls during FILL -> front unchanged, swap_pending==1; next v_sync
//    fall after FILL -> front==all ones, swap_pending==0.
//  6 Out-of-range cmd (x=40,y=0) and (x=0,y=31) -> handshake completes, back unchanged
//    (verify via swap: data identical to prior frame).

Source files
------------

// File: rtl/tile_framebuffer.sv
// Double-buffered 40x30 monochrome tile store for the VGA scan-out stage.
// Game logic edits the back buffer through a valid/ready command port; a
// requested swap copies back -> front on the next falling edge of v_sync,
// but only while no FILL sweep is running, so a frame is never torn.
module tile_framebuffer #(
  parameter int COLS  = 40,
  parameter int ROWS  = 30,
  parameter int TILES = COLS * ROWS
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [1:0]     cmd_op,
  input  logic [5:0]     cmd_x,
  input  logic [4:0]     cmd_y,
  input  logic           cmd_value,
  input  logic           swap_req,
  input  logic           v_sync,
  output logic           swap_pending,
  output logic           busy,
  output logic [TILES:0] data
);

  typedef enum logic [1:0] {
    OP_SET    = 2'b00,
    OP_CLEAR  = 2'b01,
    OP_TOGGLE = 2'b10,
    OP_FILL   = 2'b11
  } op_t;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t           state;
  logic [TILES-1:0] back;
  logic [TILES-1:0] front;
  logic [4:0]       row;
  logic             fill_value;

  logic             vs_s1, vs_s2, vs_s3;
  logic             vs_fall;
  logic [10:0]      idx;
  logic [10:0]      row_base;
  logic             in_range;
  logic             accept;
  logic             do_swap;

  // Linear tile index and row base; out-of-range coordinates are masked by in_range.
  assign idx      = 11'(cmd_y) * 11'(COLS) + 11'(cmd_x);
  assign row_base = 11'(row) * 11'(COLS);
  assign in_range = (cmd_x < 6'(COLS)) && (cmd_y < 5'(ROWS));
  assign accept   = cmd_valid & cmd_ready;

  // s3 is one flop behind the synchronized level, so this is a 1-cycle pulse per frame.
  assign vs_fall  = vs_s3 & ~vs_s2;
  assign do_swap  = vs_fall & swap_pending & (state == IDLE);

  // The VGA stage only ever sees the front register; top bit is unused by the consumer.
  assign data = {1'b0, front};

  // Two-flop synchronizer for v_sync plus a delay flop for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_s1 <= 1'b1;
      vs_s2 <= 1'b1;
      vs_s3 <= 1'b1;
    end else begin
      vs_s1 <= v_sync;
      vs_s2 <= vs_s1;
      vs_s3 <= vs_s2;
    end
  end

  // Command FSM: single-tile edits in IDLE, one 40-tile row per cycle in FILL.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      back       <= '0;
      row        <= '0;
      fill_value <= 1'b0;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            case (op_t'(cmd_op))
              OP_SET:    if (in_range) back[idx] <= 1'b1;
              OP_CLEAR:  if (in_range) back[idx] <= 1'b0;
              OP_TOGGLE: if (in_range) back[idx] <= ~back[idx];
              OP_FILL: begin
                fill_value <= cmd_value;
                row        <= '0;
                state      <= FILL;
                cmd_ready  <= 1'b0;
                busy       <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        FILL: begin
          back[row_base +: COLS] <= {COLS{fill_value}};
          if (row == 5'(ROWS - 1)) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            row <= row + 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Swap bookkeeping: copy samples back before any same-edge command lands in it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      front        <= '0;
      swap_pending <= 1'b0;
    end else if (do_swap) begin
      front        <= back;
      swap_pending <= 1'b0;
    end else if (swap_req) begin
      swap_pending <= 1'b1;
    end
  end

endmodule
